// File: rtl/rx_frame_fifo.sv
// Store-and-forward receive frame buffer: frames land speculatively in a circular
// byte RAM and are released to the AXI-Stream master only once their tlast passes checks.
module rx_frame_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int LEN_ADDR_WIDTH = 4,
  parameter bit STRIP_FCS      = 1'b1,
  parameter int MIN_FRAME      = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_rx_axis_tdata,
  input  logic                    s_rx_axis_tvalid,
  input  logic                    s_rx_axis_tlast,
  input  logic                    s_rx_axis_tuser,
  output logic                    s_rx_axis_trdy,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_trdy,
  output logic                    drop_bad_fcs,
  output logic                    drop_runt,
  output logic                    drop_overflow,
  output logic [LEN_ADDR_WIDTH:0] frame_count
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int NW = ADDR_WIDTH + 2;
  localparam int LW = LEN_ADDR_WIDTH + 1;
  localparam logic [NW-1:0] N_SAT     = NW'((1 << ADDR_WIDTH) + 1);
  localparam logic [NW-1:0] N_MIN     = NW'(MIN_FRAME);
  localparam logic [PW-1:0] RAM_DEPTH = PW'(1 << ADDR_WIDTH);
  localparam logic [LW-1:0] LEN_DEPTH = LW'(1 << LEN_ADDR_WIDTH);
  localparam logic [PW-1:0] FCS_BYTES = PW'(STRIP_FCS ? 4 : 0);

  typedef enum logic {WR_ACTIVE, WR_DROP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_DATA, RD_SKIP} rd_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  logic [DATA_WIDTH-1:0] ram     [0:(1<<ADDR_WIDTH)-1];
  logic [PW-1:0]         len_mem [0:(1<<LEN_ADDR_WIDTH)-1];

  wr_state_t     wr_state;
  rd_state_t     rd_state;
  logic [PW-1:0] wr_ptr, wr_commit, rd_ptr, ram_used, rem;
  logic [NW-1:0] n, n_next;
  logic [LW-1:0] len_wp, len_rp;
  logic [1:0]    skip_cnt, occ;
  logic          beat, wr_en, commit, ram_full, len_full, len_empty;
  logic          rd_issue, pop, ram_vld, out_vld, pf_vld;
  beat_t         ram_q, out_q, pf_q;

  // ---------------- write side ----------------
  assign beat      = s_rx_axis_tvalid && s_rx_axis_trdy;
  assign ram_used  = wr_ptr - rd_ptr;
  assign ram_full  = (ram_used == RAM_DEPTH);
  // Capacity is counted in frames not yet fully read, so a popped-but-unread
  // frame still holds its slot.
  assign len_full  = (frame_count == LEN_DEPTH);
  assign len_empty = (len_wp == len_rp);
  assign n_next    = (n == N_SAT) ? n : n + NW'(1);
  assign wr_en     = beat && (wr_state == WR_ACTIVE) && !ram_full;
  assign commit    = beat && (wr_state == WR_ACTIVE) && s_rx_axis_tlast && !s_rx_axis_tuser &&
                     (n_next >= N_MIN) && !ram_full && !len_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state       <= WR_ACTIVE;
      wr_ptr         <= '0;
      wr_commit      <= '0;
      n              <= '0;
      len_wp         <= '0;
      s_rx_axis_trdy <= 1'b0;
      drop_bad_fcs   <= 1'b0;
      drop_runt      <= 1'b0;
      drop_overflow  <= 1'b0;
    end else begin
      s_rx_axis_trdy <= 1'b1;
      drop_bad_fcs   <= 1'b0;
      drop_runt      <= 1'b0;
      drop_overflow  <= 1'b0;
      if (beat) begin
        case (wr_state)
          WR_ACTIVE: begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            n <= n_next;
            if (s_rx_axis_tlast) begin
              n <= '0;
              if (commit) begin
                wr_commit <= wr_ptr + PW'(1);
                len_wp    <= len_wp + LW'(1);
              end else begin
                wr_ptr <= wr_commit;
                if (s_rx_axis_tuser)     drop_bad_fcs  <= 1'b1;
                else if (n_next < N_MIN) drop_runt     <= 1'b1;
                else                     drop_overflow <= 1'b1;
              end
            end else if (ram_full) begin
              wr_state <= WR_DROP;
            end
          end
          WR_DROP: begin
            if (s_rx_axis_tlast) begin
              drop_overflow <= 1'b1;
              wr_ptr        <= wr_commit;
              n             <= '0;
              wr_state      <= WR_ACTIVE;
            end
          end
          default: wr_state <= WR_ACTIVE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) len_mem[len_wp[LEN_ADDR_WIDTH-1:0]] <= n_next[PW-1:0];
  end

  // Data RAM: one write port from the MAC, one registered read port for the fetcher.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr[ADDR_WIDTH-1:0]] <= s_rx_axis_tdata;
    if (rd_issue) begin
      ram_q.data <= ram[rd_ptr[ADDR_WIDTH-1:0]];
      ram_q.last <= (rem == PW'(1));
    end
  end

  // ---------------- read side ----------------
  // Two landing slots (output + prefetch); a fetch is issued only if its byte
  // is guaranteed a slot, counting the byte already in flight out of the RAM.
  assign pop      = out_vld && m_axis_trdy;
  assign occ      = {1'b0, out_vld} + {1'b0, pf_vld} + {1'b0, ram_vld} - {1'b0, pop};
  assign rd_issue = (rd_state == RD_DATA) && (rem != '0) && (occ < 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rd_ptr   <= '0;
      rem      <= '0;
      skip_cnt <= '0;
      len_rp   <= '0;
      ram_vld  <= 1'b0;
      out_q    <= '0;
      out_vld  <= 1'b0;
      pf_q     <= '0;
      pf_vld   <= 1'b0;
    end else begin
      ram_vld <= rd_issue;
      case (rd_state)
        RD_IDLE: begin
          if (!len_empty) begin
            len_rp   <= len_rp + LW'(1);
            rem      <= len_mem[len_rp[LEN_ADDR_WIDTH-1:0]] - FCS_BYTES;
            rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rd_issue) begin
            rd_ptr <= rd_ptr + PW'(1);
            rem    <= rem - PW'(1);
            if (rem == PW'(1)) begin
              skip_cnt <= '0;
              rd_state <= STRIP_FCS ? RD_SKIP : RD_IDLE;
            end
          end
        end
        RD_SKIP: begin
          rd_ptr   <= rd_ptr + PW'(1);
          skip_cnt <= skip_cnt + 2'd1;
          if (skip_cnt == 2'd3) rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase

      if (!out_vld || pop) begin
        if (pf_vld) begin
          out_q   <= pf_q;
          out_vld <= 1'b1;
          pf_q    <= ram_q;
          pf_vld  <= ram_vld;
        end else if (ram_vld) begin
          out_q   <= ram_q;
          out_vld <= 1'b1;
        end else begin
          out_q   <= '0;
          out_vld <= 1'b0;
        end
      end else if (ram_vld) begin
        pf_q   <= ram_q;
        pf_vld <= 1'b1;
      end
    end
  end

  assign m_axis_tdata  = out_q.data;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tvalid = out_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else begin
      case ({commit, pop && out_q.last})
        2'b10:   frame_count <= frame_count + LW'(1);
        2'b01:   frame_count <= frame_count - LW'(1);
        default: frame_count <= frame_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Bench for rx_frame_fifo: a 4 KiB instance for most traffic and a 128 B instance for
// RAM overflow; expected beats are queued at stimulus time and popped by monitors.
module tb_rx_frame_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_tdata, m_tdata, s2_tdata, m2_tdata;
  logic s_tvalid, s_tlast, s_tuser, s_trdy, m_tvalid, m_tlast, m_trdy;
  logic s2_tvalid, s2_tlast, s2_tuser, s2_trdy, m2_tvalid, m2_tlast, m2_trdy;
  logic d_bad, d_runt, d_ovf, d2_bad, d2_runt, d2_ovf;
  logic [4:0] fcnt, fcnt2;

  int n_chk = 0, n_fail = 0;
  int c_bad = 0, c_runt = 0, c_ovf = 0, c_ovf2 = 0, c2_other = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp2_q[$];

  rx_frame_fifo dut (
    .clk(clk), .reset(reset),
    .s_rx_axis_tdata(s_tdata), .s_rx_axis_tvalid(s_tvalid), .s_rx_axis_tlast(s_tlast),
    .s_rx_axis_tuser(s_tuser), .s_rx_axis_trdy(s_trdy),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_trdy(m_trdy),
    .drop_bad_fcs(d_bad), .drop_runt(d_runt), .drop_overflow(d_ovf), .frame_count(fcnt)
  );

  rx_frame_fifo #(.ADDR_WIDTH(7)) dut_small (
    .clk(clk), .reset(reset),
    .s_rx_axis_tdata(s2_tdata), .s_rx_axis_tvalid(s2_tvalid), .s_rx_axis_tlast(s2_tlast),
    .s_rx_axis_tuser(s2_tuser), .s_rx_axis_trdy(s2_trdy),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tlast(m2_tlast), .m_axis_trdy(m2_trdy),
    .drop_bad_fcs(d2_bad), .drop_runt(d2_runt), .drop_overflow(d2_ovf), .frame_count(fcnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic mon(input bit which);
    logic [9:0] cur, held;
    logic [8:0] e;
    logic rdy;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = which ? {m2_tvalid, m2_tlast, m2_tdata} : {m_tvalid, m_tlast, m_tdata};
      rdy = which ? m2_trdy : m_trdy;
      if (stalled && !reset) check("stall_hold", 32'(cur), 32'(held));
      if (cur[9] && rdy) begin
        if ((which ? exp2_q.size() : exp_q.size()) == 0) begin
          check("beat_expected", 32'((which ? exp2_q.size() : exp_q.size()) != 0), 32'd1);
        end else begin
          e = which ? exp2_q.pop_front() : exp_q.pop_front();
          check(which ? "out_beat_small" : "out_beat", 32'(cur[8:0]), 32'(e));
        end
      end
      stalled = cur[9] && !rdy;
      held = cur;
    end
  endtask

  task automatic drop_mon();
    forever begin
      @(negedge clk);
      if (d_bad)  c_bad++;
      if (d_runt) c_runt++;
      if (d_ovf)  c_ovf++;
      if (d2_ovf) c_ovf2++;
      if (d2_bad || d2_runt) c2_other++;
    end
  endtask

  // Bytes are base, base+1, ...; when keep is set the frame minus its FCS is queued.
  task automatic send_frame(input bit which, input int len, input bit bad,
                            input logic [7:0] base, input bit keep);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      b = base + 8'(i);
      if (which) begin
        s2_tvalid = 1'b1; s2_tdata = b; s2_tlast = (i == len-1); s2_tuser = bad && (i == len-1);
      end else begin
        s_tvalid = 1'b1; s_tdata = b; s_tlast = (i == len-1); s_tuser = bad && (i == len-1);
      end
      if (keep && i < len-4) begin
        if (which) exp2_q.push_back({i == len-5, b});
        else       exp_q.push_back({i == len-5, b});
      end
    end
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    s2_tvalid = 1'b0; s2_tlast = 1'b0; s2_tuser = 1'b0;
  endtask

  task automatic drain(input bit which, input int budget);
    int t;
    t = 0;
    while ((which ? exp2_q.size() : exp_q.size()) != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(which ? "drain_small" : "drain_main", 32'(which ? exp2_q.size() : exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lat, t;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; m_trdy = 1'b1;
    s2_tdata = '0; s2_tvalid = 1'b0; s2_tlast = 1'b0; s2_tuser = 1'b0; m2_trdy = 1'b0;
    fork
      mon(1'b0);
      mon(1'b1);
      drop_mon();
    join_none

    // reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({s_trdy, m_tvalid, m_tlast, m_tdata, d_bad, d_runt, d_ovf, fcnt}), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("trdy_before_edge", 32'(s_trdy), 32'd0);
    @(negedge clk);
    check("trdy_after_edge", 32'(s_trdy), 32'd1);

    // good 64-byte frame, FCS stripped
    send_frame(1'b0, 64, 1'b0, 8'h00, 1'b1);
    end_frame();
    check("frame_count_commit", 32'(fcnt), 32'd1);
    lat = 0;
    while (!m_tvalid && lat < 4) begin @(posedge clk); #1; lat++; end
    check("first_byte_latency_le3", 32'(lat <= 3), 32'd1);
    drain(1'b0, 200);
    check("frame_count_read", 32'(fcnt), 32'd0);

    // bad FCS, then a good frame behind it
    send_frame(1'b0, 100, 1'b1, 8'h40, 1'b0);
    end_frame();
    repeat (3) @(negedge clk);
    check("drop_bad_fcs_cnt", 32'(c_bad), 32'd1);
    check("no_commit_bad", 32'(fcnt), 32'd0);
    send_frame(1'b0, 64, 1'b0, 8'h80, 1'b1);
    end_frame();
    drain(1'b0, 200);

    // runt
    send_frame(1'b0, 40, 1'b0, 8'hC0, 1'b0);
    end_frame();
    repeat (3) @(negedge clk);
    check("drop_runt_cnt", 32'(c_runt), 32'd1);
    check("bad_cnt_unchanged", 32'(c_bad), 32'd1);
    check("no_commit_runt", 32'(fcnt), 32'd0);

    // 128-byte RAM overflow with downstream stalled
    send_frame(1'b1, 100, 1'b0, 8'h10, 1'b1);
    send_frame(1'b1, 64, 1'b0, 8'h90, 1'b0);
    end_frame();
    repeat (3) @(negedge clk);
    check("small_drop_ovf_cnt", 32'(c_ovf2), 32'd1);
    check("small_frame_count", 32'(fcnt2), 32'd1);
    check("small_other_drops", 32'(c2_other), 32'd0);
    @(posedge clk); #1; m2_trdy = 1'b1;
    drain(1'b1, 400);
    check("small_frame_count_read", 32'(fcnt2), 32'd0);

    // 17 back-to-back frames, length FIFO fills at 16
    @(posedge clk); #1; m_trdy = 1'b0;
    for (int k = 0; k < 17; k++) send_frame(1'b0, 64, 1'b0, 8'(k * 16), k < 16);
    end_frame();
    repeat (3) @(negedge clk);
    check("lenfifo_drop_ovf_cnt", 32'(c_ovf), 32'd1);
    check("lenfifo_frame_count", 32'(fcnt), 32'd16);
    @(posedge clk); #1; m_trdy = 1'b1;
    drain(1'b0, 3000);
    check("frame_count_after_16", 32'(fcnt), 32'd0);

    // random back-pressure on a 200-byte frame, then reset mid-read
    fork
      send_frame(1'b0, 200, 1'b0, 8'h33, 1'b1);
      repeat (200) begin @(posedge clk); #1; m_trdy = 1'($urandom_range(0, 1)); end
    join
    end_frame();
    t = 0;
    while (exp_q.size() > 100 && t < 2000) begin
      @(posedge clk); #1;
      m_trdy = 1'($urandom_range(0, 1));
      t++;
    end
    check("reached_mid_read", 32'(exp_q.size() <= 100), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midread_reset_outputs", 32'({s_trdy, m_tvalid, m_tlast, m_tdata, d_bad, d_runt, d_ovf, fcnt}), 32'd0);
    exp_q.delete();
    @(posedge clk); #1; reset = 1'b0; m_trdy = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_trdy", 32'(s_trdy), 32'd1);
    check("post_reset_empty", 32'({m_tvalid, fcnt}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
